clock_display_scan: RTL and testbench
=====================================

CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is shown (legal range >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pm  input  1  PM flag from the twelve-hour clock.
REQ-005 SHALL have port hh  input  8  hours, packed BCD {tens,units}, 01..12.
REQ-006 SHALL have port mm  input  8  minutes, packed BCD, 00..59.
REQ-007 SHALL have port ss  input  8  seconds, packed BCD, 00..59.
REQ-008 SHALL have port an  output  6  active-low digit enables; bit 5 = hour tens (leftmost), bit 0 = seconds units.
REQ-009 SHALL have port seg  output  7  active-low segments; seg[6]=a ... seg[0]=g.
REQ-010 SHALL have port dp  output  1  active-low decimal point for the enabled digit.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse when a new time snapshot is taken.
REQ-012 SHALL have port bcd_err  output  1  one-cycle pulse when the displayed nibble is > 9.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index d (0..5) SHALL advance by one on each wrap and go from 5 to 0.
REQ-014 Digit order: d=0 hh tens, 1 hh units, 2 mm tens, 3 mm units, 4 ss tens, 5 ss units.
REQ-015 Snapshot registers (pm, hh, mm, ss) SHALL load from the inputs on each edge where prescaler==0 and d==0; input changes at any other time SHALL NOT affect the frame in progress.
REQ-016 frame_start SHALL be 1 for exactly the cycle after each snapshot load.
REQ-017 an, seg, dp, and bcd_err SHALL be registered from (d, snapshot), giving one cycle of latency behind d; an SHALL have exactly one bit low, bit (5-d).
REQ-018 seg encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; nibble > 9 = 1111110 (dash only).
REQ-019 bcd_err SHALL pulse for one cycle on each registered digit update whose nibble is > 9, that is, once per affected digit per frame.
REQ-020 dp SHALL be 0 on digits 1 and 3 when the snapshot ss units bit 0 is 0 (colon blinks at 0.5 Hz); dp SHALL be 0 on digit 5 when the snapshot pm is 1; dp SHALL be 1 otherwise.
REQ-021 The block SHALL NOT range-check hh, mm, or ss beyond per-nibble BCD validity.

Reset
REQ-022 While reset is 1: prescaler=0, d=0, snapshot=0, an=111111, seg=1111111, dp=1, frame_start=0, bcd_err=0.
REQ-023 On the first edge after reset deasserts, the snapshot SHALL load, so the first frame shows the live inputs.
REQ-024 Asserting reset mid-frame SHALL abort the scan on the next edge, with no partial-digit carry-over.

Configuration
REQ-025 Macro CLOCK_DISPLAY_LEADING_BLANK_EN: when defined, hour tens digit 0 SHALL drive seg=1111111, with an still enabled and dp per REQ-020; when undefined, it SHALL show "0" (0000001).

Verification (SCAN_DIV=4)
REQ-026 Reset 3 cycles, hh=8'h09, mm=8'h45, ss=8'h30, pm=0 -> frame_start pulse; digits in order 0,9,4,5,3,0, each held 4 cycles; dp low on digits 1 and 3; an walks 011111..111110.
REQ-027 pm=1, ss=8'h31 -> dp high on digits 1 and 3; dp low on digit 5 only.
REQ-028 Change mm from 8'h45 to 8'h46 while d=2 -> current frame still shows 4,5; next frame shows 4,6.
REQ-029 hh=8'h1A -> digit 1 seg=1111110 and one bcd_err pulse per frame.
REQ-030 Assert reset while d=3 -> next cycle all outputs at reset values; after release, scan restarts at d=0 with frame_start.
REQ-031 hh=8'h07 with and without CLOCK_DISPLAY_LEADING_BLANK_EN -> digit 0 seg=1111111 when defined, 0000001 when not.

Source files
------------

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for an hh:mm:ss twelve-hour clock.
// Optional build macro: CLOCK_DISPLAY_LEADING_BLANK_EN blanks a zero hour-tens digit.
module clock_display_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start,
    output logic       bcd_err
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

    typedef struct packed {
        logic       pm;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } snap_t;

    logic [PW-1:0] presc;
    logic [2:0]    d;
    snap_t         snap;
    snap_t         live;
    snap_t         view;
    logic          load;
    logic [3:0]    nib;
    logic [6:0]    dig_seg;
    logic          dig_dp;

    assign live = {pm, hh, mm, ss};
    assign load = (presc == '0) && (d == 3'd0);
    // Forward the inputs on the load edge so digit 0 of a new frame never shows stale data.
    assign view = load ? live : snap;

    always_comb begin
        nib = 4'd0;
        case (d)
            3'd0:    nib = view.hh[7:4];
            3'd1:    nib = view.hh[3:0];
            3'd2:    nib = view.mm[7:4];
            3'd3:    nib = view.mm[3:0];
            3'd4:    nib = view.ss[7:4];
            3'd5:    nib = view.ss[3:0];
            default: nib = 4'd0;
        endcase
    end

    always_comb begin
        dig_seg = 7'b1111110;
        case (nib)
            4'd0:    dig_seg = 7'b0000001;
            4'd1:    dig_seg = 7'b1001111;
            4'd2:    dig_seg = 7'b0010010;
            4'd3:    dig_seg = 7'b0000110;
            4'd4:    dig_seg = 7'b1001100;
            4'd5:    dig_seg = 7'b0100100;
            4'd6:    dig_seg = 7'b0100000;
            4'd7:    dig_seg = 7'b0001111;
            4'd8:    dig_seg = 7'b0000000;
            4'd9:    dig_seg = 7'b0000100;
            default: dig_seg = 7'b1111110;
        endcase
`ifdef CLOCK_DISPLAY_LEADING_BLANK_EN
        if (d == 3'd0 && nib == 4'd0)
            dig_seg = 7'b1111111;
`endif
    end

    // Colon dots on digits 1 and 3 follow the seconds LSB; digit 5 dot marks PM.
    always_comb begin
        dig_dp = 1'b1;
        if (d == 3'd1 || d == 3'd3)
            dig_dp = view.ss[0];
        else if (d == 3'd5)
            dig_dp = ~view.pm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            d           <= 3'd0;
            snap        <= '0;
            an          <= 6'b111111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            frame_start <= 1'b0;
            bcd_err     <= 1'b0;
        end else begin
            if (presc == PLAST) begin
                presc <= '0;
                d     <= (d == 3'd5) ? 3'd0 : d + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (load)
                snap <= live;
            frame_start <= load;
            bcd_err     <= 1'b0;
            // Outputs refresh once per digit, so bcd_err fires once per bad digit per frame.
            if (presc == '0) begin
                an      <= ~(6'b100000 >> d);
                seg     <= dig_seg;
                dp      <= dig_dp;
                bcd_err <= (nib > 4'd9);
            end
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan (SCAN_DIV=4): driver pushes expected digits, monitor checks.
module tb_clock_display_scan;

    localparam int SD = 4;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pm = 1'b0;
    logic [7:0] hh = 8'h00;
    logic [7:0] mm = 8'h00;
    logic [7:0] ss = 8'h00;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;
    logic       bcd_err;

    clock_display_scan #(.SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       err;
        logic       fs;
    } obs_t;

    obs_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 1'b0;
    obs_t prev = {6'h3f, 7'h7f, 1'b1, 1'b0, 1'b0};

    function automatic logic [6:0] seg_of(input logic [3:0] n, input bit lead);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
`ifdef CLOCK_DISPLAY_LEADING_BLANK_EN
        if (lead && n == 4'd0) s = 7'b1111111;
`endif
        return s;
    endfunction

    // dpm/errm: bit k is the expected dp / bcd_err for digit k.
    task automatic push_frame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                              input logic [5:0] dpm, input logic [5:0] errm, input int ndig);
        logic [3:0] nb [6];
        logic [5:0] onehot;
        obs_t e;
        nb = '{h[7:4], h[3:0], m[7:4], m[3:0], s[7:4], s[3:0]};
        onehot = 6'b100000;
        for (int k = 0; k < ndig; k++) begin
            e.an  = ~(onehot >> k);
            e.seg = seg_of(nb[k], k == 0);
            e.dp  = dpm[k];
            e.err = errm[k];
            e.fs  = (k == 0);
            sb.push_back(e);
        end
    endtask

    // Entered at the negedge just before a snapshot edge; returns at the next such negedge.
    task automatic run_frame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                             input logic p, input logic [5:0] dpm, input logic [5:0] errm,
                             input int chg_at, input logic [7:0] m2);
        hh = h; mm = m; ss = s; pm = p;
        push_frame(h, m, s, dpm, errm, 6);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c == chg_at) mm = m2;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        obs_t cur;
        cur = {an, seg, dp, bcd_err, frame_start};
        vectors++;
        if (cur !== {6'h3f, 7'h7f, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s: got an=%b seg=%b dp=%b err=%b fs=%b, want an=111111 seg=1111111 dp=1 err=0 fs=0",
                     name, an, seg, dp, bcd_err, frame_start);
        end
    endtask

    // Monitor: a new digit (change of an) pops one expected entry; held cycles must stay stable.
    always @(negedge clk) begin
        obs_t cur;
        obs_t e;
        if (!done) begin
            cur = {an, seg, dp, bcd_err, frame_start};
            if (an != prev.an && an != 6'h3f) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL digit_unexpected: got an=%b with no expected entry", an);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL digit: got an=%b seg=%b dp=%b err=%b fs=%b, want an=%b seg=%b dp=%b err=%b fs=%b",
                                 an, seg, dp, bcd_err, frame_start, e.an, e.seg, e.dp, e.err, e.fs);
                    end
                end
            end else if (an == prev.an && an != 6'h3f) begin
                vectors++;
                if ({seg, dp} !== {prev.seg, prev.dp} || bcd_err !== 1'b0 || frame_start !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold: an=%b got seg=%b dp=%b err=%b fs=%b, want seg=%b dp=%b err=0 fs=0",
                             an, seg, dp, bcd_err, frame_start, prev.seg, prev.dp);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries still queued", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;

        // 09:45:30 AM, then PM with odd seconds.
        run_frame(8'h09, 8'h45, 8'h30, 1'b0, 6'b110101, 6'b000000, -1, 8'h00);
        run_frame(8'h09, 8'h45, 8'h31, 1'b1, 6'b011111, 6'b000000, -1, 8'h00);
        // Minutes change while d=2: this frame keeps 45, the next shows 46.
        run_frame(8'h09, 8'h45, 8'h30, 1'b0, 6'b110101, 6'b000000, 8, 8'h46);
        run_frame(8'h09, 8'h46, 8'h30, 1'b0, 6'b110101, 6'b000000, -1, 8'h00);
        // Invalid hour units nibble, two frames -> one bcd_err per frame.
        run_frame(8'h1A, 8'h46, 8'h31, 1'b0, 6'b111111, 6'b000010, -1, 8'h00);
        run_frame(8'h1A, 8'h46, 8'h31, 1'b0, 6'b111111, 6'b000010, -1, 8'h00);

        // Reset asserted while digit 3 is shown.
        hh = 8'h12; mm = 8'h59; ss = 8'h58; pm = 1'b1;
        push_frame(8'h12, 8'h59, 8'h58, 6'b010101, 6'b000000, 4);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_abort");
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL abort_digits: %0d expected digits not shown before reset, want 0", sb.size());
            sb.delete();
        end
        reset = 1'b0;
        run_frame(8'h12, 8'h59, 8'h58, 1'b1, 6'b010101, 6'b000000, -1, 8'h00);

        // Zero hour tens (blanked only with the leading-blank build) and multiple bad nibbles.
        run_frame(8'h07, 8'h00, 8'h00, 1'b0, 6'b110101, 6'b000000, -1, 8'h00);
        run_frame(8'h11, 8'hE0, 8'h0F, 1'b0, 6'b111111, 6'b100100, -1, 8'h00);

        reset = 1'b1;
        @(negedge clk);
        done = 1'b1;
        check_reset_outputs("final_reset");
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected digits never shown, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
